pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_pkg.sv | 24 ++
 rtl/pipe_stage_reg_if.sv | 39 +++
 rtl/pipe_stage_reg_cell.sv | 33 +++
 rtl/pipe_stage_reg.sv | 94 +++++++++
 tb/tb_pipe_stage_reg.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants, occupancy width helper and per-stage tag record for pipe_stage_reg.
// PIPE_STAGE_REG_PARITY_EN adds an even-parity bit to each stage tag.
package pipe_stage_pkg;

    localparam int MAX_DEPTH = 8;
    localparam int MAX_WIDTH = 64;

    function automatic int occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Per-stage record is {data[WIDTH], stage_tag_t}; the tag part is width independent.
`ifdef PIPE_STAGE_REG_PARITY_EN
    typedef struct packed {
        logic vld;
        logic par;
    } stage_tag_t;
`else
    typedef struct packed {
        logic vld;
    } stage_tag_t;
`endif

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Operand bus of pipe_stage_reg: control, input word and delayed output word.
// PIPE_STAGE_REG_PARITY_EN adds the parity error outputs.
interface pipe_stage_reg_if
    import pipe_stage_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 1
);
    localparam int OCC_W = occ_width(DEPTH);

    logic             CE;
    logic             FLUSH;
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [OCC_W-1:0] occupancy;
`ifdef PIPE_STAGE_REG_PARITY_EN
    logic             parity_err;
    logic             parity_err_sticky;
`endif

    modport master (
        output CE, FLUSH, din, din_vld,
`ifdef PIPE_STAGE_REG_PARITY_EN
        input  parity_err, parity_err_sticky,
`endif
        input  dout, dout_vld, occupancy
    );

    modport slave (
        input  CE, FLUSH, din, din_vld,
`ifdef PIPE_STAGE_REG_PARITY_EN
        output parity_err, parity_err_sticky,
`endif
        output dout, dout_vld, occupancy
    );

endinterface

// File: rtl/pipe_stage_reg_cell.sv
// One pipeline stage: data word plus tag, with synchronous RESET/FLUSH and CE hold.
module pipe_stage_cell
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH   = 18,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] d_data,
    input  stage_tag_t       d_tag,
    output logic [WIDTH-1:0] q_data,
    output stage_tag_t       q_tag
);
    logic [WIDTH-1:0] data_q;
    stage_tag_t       tag_q;

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH) begin
            data_q <= RST_VAL;
            tag_q  <= '0;
        end else if (CE) begin
            data_q <= d_data;
            tag_q  <= d_tag;
        end
    end

    assign q_data = data_q;
    assign q_tag  = tag_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage operand delay line with stall, flush, valid tags and occupancy count.
// PIPE_STAGE_REG_PARITY_EN adds per-stage even parity and parity error flags.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH   = 18,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic             CLK,
    input logic             RESET,
    pipe_stage_reg_if.slave bus
);
    localparam int OCC_W = occ_width(DEPTH);

    if (DEPTH < 0 || DEPTH > MAX_DEPTH || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $error("pipe_stage_reg: DEPTH must be 0..8 and WIDTH 1..64");
    end

    if (DEPTH == 0) begin : g_bypass
        logic unused_ok;
        assign unused_ok     = ^{CLK, RESET, bus.CE, bus.FLUSH};
        assign bus.dout      = bus.din;
        assign bus.dout_vld  = bus.din_vld;
        assign bus.occupancy = '0;
`ifdef PIPE_STAGE_REG_PARITY_EN
        assign bus.parity_err        = 1'b0;
        assign bus.parity_err_sticky = 1'b0;
`endif
    end else begin : g_pipe
        logic [DEPTH:0][WIDTH-1:0] data_pipe;
        stage_tag_t [DEPTH:0]      tag_pipe;
        logic [OCC_W-1:0]          occ_q;
        logic                      enter;
        logic                      leave;

        assign data_pipe[0] = bus.din;
`ifdef PIPE_STAGE_REG_PARITY_EN
        assign tag_pipe[0]  = '{vld: bus.din_vld, par: ^bus.din};
`else
        assign tag_pipe[0]  = '{vld: bus.din_vld};
`endif

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            pipe_stage_cell #(
                .WIDTH  (WIDTH),
                .RST_VAL(RST_VAL)
            ) u_cell (
                .CLK   (CLK),
                .RESET (RESET),
                .CE    (bus.CE),
                .FLUSH (bus.FLUSH),
                .d_data(data_pipe[k]),
                .d_tag (tag_pipe[k]),
                .q_data(data_pipe[k+1]),
                .q_tag (tag_pipe[k+1])
            );
        end

        // Occupancy tracks the valid popcount incrementally: one in, one out per CE edge.
        assign enter = bus.din_vld;
        assign leave = tag_pipe[DEPTH].vld;

        always_ff @(posedge CLK) begin
            if (RESET || bus.FLUSH) begin
                occ_q <= '0;
            end else if (bus.CE) begin
                if (enter && !leave)      occ_q <= occ_q + 1'b1;
                else if (!enter && leave) occ_q <= occ_q - 1'b1;
            end
        end

        assign bus.dout      = data_pipe[DEPTH];
        assign bus.dout_vld  = tag_pipe[DEPTH].vld;
        assign bus.occupancy = occ_q;

`ifdef PIPE_STAGE_REG_PARITY_EN
        logic par_err;
        logic sticky_q;

        assign par_err = tag_pipe[DEPTH].vld & ((^data_pipe[DEPTH]) != tag_pipe[DEPTH].par);

        // Sticky survives FLUSH so a corrupted word is not lost by a pipeline clear.
        always_ff @(posedge CLK) begin
            if (RESET)        sticky_q <= 1'b0;
            else if (par_err) sticky_q <= 1'b1;
        end

        assign bus.parity_err        = par_err;
        assign bus.parity_err_sticky = sticky_q;
`endif
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised self-checking bench for pipe_stage_reg (DEPTH 3, 4 and 0 instances;
// DEPTH 2 parity instance when PIPE_STAGE_REG_PARITY_EN is defined).
module tb_pipe_stage_reg;

    localparam logic [17:0] RV4 = 18'h2A5A5;

    typedef struct {
        logic [17:0] d;
        logic        v;
    } samp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // Model: history of words accepted on CE edges since the last reset/flush.
    samp_t h3[$];
    samp_t h4[$];

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.WIDTH(18), .DEPTH(3)) if3 ();
    pipe_stage_reg_if #(.WIDTH(18), .DEPTH(4)) if4 ();
    pipe_stage_reg_if #(.WIDTH(18), .DEPTH(0)) if0 ();

    pipe_stage_reg #(.WIDTH(18), .DEPTH(3), .RST_VAL(18'h0)) dut3 (.CLK(clk), .RESET(rst), .bus(if3));
    pipe_stage_reg #(.WIDTH(18), .DEPTH(4), .RST_VAL(RV4))   dut4 (.CLK(clk), .RESET(rst), .bus(if4));
    pipe_stage_reg #(.WIDTH(18), .DEPTH(0), .RST_VAL(18'h0)) dut0 (.CLK(clk), .RESET(rst), .bus(if0));

`ifdef PIPE_STAGE_REG_PARITY_EN
    pipe_stage_reg_if #(.WIDTH(18), .DEPTH(2)) if2 ();
    pipe_stage_reg #(.WIDTH(18), .DEPTH(2), .RST_VAL(18'h0)) dp (.CLK(clk), .RESET(rst), .bus(if2));
`endif

    function automatic logic [18:0] exp_out(input samp_t h[$], input int dep, input logic [17:0] rv);
        if (h.size() >= dep) return {h[h.size()-dep].d, h[h.size()-dep].v};
        return {rv, 1'b0};
    endfunction

    function automatic int exp_occ(input samp_t h[$], input int dep);
        int n = 0;
        for (int i = 0; i < h.size(); i++)
            if (i >= h.size() - dep && h[i].v) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst || if3.FLUSH) h3.delete();
        else if (if3.CE) begin
            h3.push_back('{if3.din, if3.din_vld});
            if (h3.size() > 3) h3.delete(0);
        end
        if (rst || if4.FLUSH) h4.delete();
        else if (if4.CE) begin
            h4.push_back('{if4.din, if4.din_vld});
            if (h4.size() > 4) h4.delete(0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if3.CE = 1'b1; if3.FLUSH = 1'b0; if3.din = 18'h3FFFF; if3.din_vld = 1'b1;
        if4.CE = 1'b1; if4.FLUSH = 1'b0; if4.din = 18'h01234; if4.din_vld = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (if3.dout !== 18'h0 || if3.dout_vld !== 1'b0 || if3.occupancy !== 2'd0) begin
                bad++;
                $display("FAIL reset3 cyc=%0d got dout=%h vld=%b occ=%0d want 0/0/0",
                         c, if3.dout, if3.dout_vld, if3.occupancy);
            end
            total++;
            if (if4.dout !== RV4 || if4.dout_vld !== 1'b0 || if4.occupancy !== 3'd0) begin
                bad++;
                $display("FAIL reset4 cyc=%0d got dout=%h vld=%b occ=%0d want %h/0/0",
                         c, if4.dout, if4.dout_vld, if4.occupancy, RV4);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            total++;
            if (if3.dout_vld !== (e == 3) || if3.occupancy !== 2'(e) ||
                if3.dout !== ((e == 3) ? 18'h3FFFF : 18'h0)) begin
                bad++;
                $display("FAIL reset_release edge=%0d got dout=%h vld=%b occ=%0d want vld=%b occ=%0d",
                         e, if3.dout, if3.dout_vld, if3.occupancy, (e == 3), e);
            end
        end
    endtask

    task automatic test_latency();
        if3.FLUSH = 1'b1; tick(); if3.FLUSH = 1'b0;
        if3.CE = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            if3.din = 18'(e); if3.din_vld = 1'b1;
            tick();
            total++;
            if (if3.occupancy !== 2'((e < 3) ? e : 3) || if3.dout_vld !== (e >= 3) ||
                if3.dout !== ((e >= 3) ? 18'(e - 2) : 18'h0)) begin
                bad++;
                $display("FAIL latency edge=%0d got dout=%0d vld=%b occ=%0d want dout=%0d vld=%b occ=%0d",
                         e, if3.dout, if3.dout_vld, if3.occupancy,
                         (e >= 3) ? e - 2 : 0, (e >= 3), (e < 3) ? e : 3);
            end
        end
    endtask

    task automatic test_stall();
        if3.FLUSH = 1'b1; tick(); if3.FLUSH = 1'b0;
        if3.CE = 1'b1; if3.din_vld = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            if3.din = 18'(i);
            tick();
        end
        total++;
        if (if3.dout !== 18'd5 || if3.occupancy !== 2'd3) begin
            bad++;
            $display("FAIL stall_fill got dout=%0d occ=%0d want 5/3", if3.dout, if3.occupancy);
        end
        if3.CE = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if3.din = 18'($urandom); if3.din_vld = 1'($urandom);
            tick();
            total++;
            if (if3.dout !== 18'd5 || if3.dout_vld !== 1'b1 || if3.occupancy !== 2'd3) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got dout=%0d vld=%b occ=%0d want 5/1/3",
                         c, if3.dout, if3.dout_vld, if3.occupancy);
            end
        end
        if3.CE = 1'b1; if3.din_vld = 1'b1;
        for (int i = 6; i <= 7; i++) begin
            if3.din = 18'(i + 2);
            tick();
            total++;
            if (if3.dout !== 18'(i) || if3.occupancy !== 2'd3) begin
                bad++;
                $display("FAIL stall_resume got dout=%0d occ=%0d want %0d/3", if3.dout, if3.occupancy, i);
            end
        end
    endtask

    task automatic test_flush();
        logic [17:0] first;
        for (int pass = 0; pass < 2; pass++) begin
            if4.FLUSH = 1'b1; tick(); if4.FLUSH = 1'b0;
            if4.CE = 1'b1; if4.din_vld = 1'b1;
            first = 18'($urandom);
            for (int i = 0; i < 4; i++) begin
                if4.din = (i == 0) ? first : 18'($urandom);
                tick();
            end
            total++;
            if (if4.occupancy !== 3'd4 || if4.dout !== first || if4.dout_vld !== 1'b1) begin
                bad++;
                $display("FAIL flush_fill pass=%0d got dout=%h occ=%0d want %h/4",
                         pass, if4.dout, if4.occupancy, first);
            end
            if4.FLUSH = 1'b1; if4.CE = 1'b0; if4.din_vld = 1'b1;
            if (pass == 1) rst = 1'b1;
            tick();
            rst = 1'b0; if4.FLUSH = 1'b0;
            total++;
            if (if4.occupancy !== 3'd0 || if4.dout !== RV4 || if4.dout_vld !== 1'b0) begin
                bad++;
                $display("FAIL flush_clear pass=%0d got dout=%h vld=%b occ=%0d want %h/0/0",
                         pass, if4.dout, if4.dout_vld, if4.occupancy, RV4);
            end
        end
    endtask

    task automatic test_bypass();
        logic [17:0] d;
        logic        v;
        for (int i = 0; i < 8; i++) begin
            d = (i == 0) ? 18'h155 : 18'($urandom);
            v = (i == 0) ? 1'b1 : 1'($urandom);
            if0.din = d; if0.din_vld = v;
            if0.CE = 1'($urandom); if0.FLUSH = 1'($urandom);
            rst = (i == 3);
            #1;
            total++;
            if (if0.dout !== d || if0.dout_vld !== v || if0.occupancy !== 1'b0) begin
                bad++;
                $display("FAIL bypass i=%0d got dout=%h vld=%b occ=%0d want %h/%b/0",
                         i, if0.dout, if0.dout_vld, if0.occupancy, d, v);
            end
            if (i[0]) tick();
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [17:0] ed;
        logic        ev;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            if3.CE = ($urandom_range(0, 9) < 7); if3.FLUSH = ($urandom_range(0, 19) == 0);
            if3.din = 18'($urandom); if3.din_vld = 1'($urandom);
            if4.CE = ($urandom_range(0, 9) < 6); if4.FLUSH = ($urandom_range(0, 24) == 0);
            if4.din = 18'($urandom); if4.din_vld = ($urandom_range(0, 3) != 0);
            tick();
            {ed, ev} = exp_out(h3, 3, 18'h0);
            total++;
            if (if3.dout !== ed || if3.dout_vld !== ev) begin
                bad++;
                $display("FAIL rand3_out cyc=%0d got %h/%b want %h/%b", c, if3.dout, if3.dout_vld, ed, ev);
            end
            total++;
            if (if3.occupancy !== 2'(exp_occ(h3, 3))) begin
                bad++;
                $display("FAIL rand3_occ cyc=%0d got %0d want %0d", c, if3.occupancy, exp_occ(h3, 3));
            end
            {ed, ev} = exp_out(h4, 4, RV4);
            total++;
            if (if4.dout !== ed || if4.dout_vld !== ev) begin
                bad++;
                $display("FAIL rand4_out cyc=%0d got %h/%b want %h/%b", c, if4.dout, if4.dout_vld, ed, ev);
            end
            total++;
            if (if4.occupancy !== 3'(exp_occ(h4, 4))) begin
                bad++;
                $display("FAIL rand4_occ cyc=%0d got %0d want %0d", c, if4.occupancy, exp_occ(h4, 4));
            end
        end
        rst = 1'b0;
    endtask

`ifdef PIPE_STAGE_REG_PARITY_EN
    task automatic test_parity();
        if2.FLUSH = 1'b0; if2.CE = 1'b1; if2.din = 18'h3; if2.din_vld = 1'b1;
        tick();
        if2.din = 18'h0; if2.din_vld = 1'b0;
        tick();
        total++;
        if (if2.dout !== 18'h3 || if2.parity_err !== 1'b0 || if2.parity_err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL parity_clean got dout=%h err=%b sticky=%b want 3/0/0",
                     if2.dout, if2.parity_err, if2.parity_err_sticky);
        end
        if2.CE = 1'b0;
        force dp.g_pipe.g_stage[1].u_cell.data_q = 18'h2;
        #1;
        total++;
        if (if2.parity_err !== 1'b1) begin
            bad++;
            $display("FAIL parity_err got %b want 1", if2.parity_err);
        end
        tick();
        release dp.g_pipe.g_stage[1].u_cell.data_q;
        total++;
        if (if2.parity_err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL parity_sticky_set got %b want 1", if2.parity_err_sticky);
        end
        if2.FLUSH = 1'b1; tick(); if2.FLUSH = 1'b0;
        total++;
        if (if2.parity_err_sticky !== 1'b1 || if2.parity_err !== 1'b0) begin
            bad++;
            $display("FAIL parity_flush got sticky=%b err=%b want 1/0", if2.parity_err_sticky, if2.parity_err);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if (if2.parity_err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL parity_reset got sticky=%b want 0", if2.parity_err_sticky);
        end
    endtask
`endif

    initial begin
        if0.CE = 1'b0; if0.FLUSH = 1'b0; if0.din = '0; if0.din_vld = 1'b0;
`ifdef PIPE_STAGE_REG_PARITY_EN
        if2.CE = 1'b0; if2.FLUSH = 1'b0; if2.din = '0; if2.din_vld = 1'b0;
`endif
        test_reset();
        test_latency();
        test_stall();
        test_flush();
        test_bypass();
        test_random();
`ifdef PIPE_STAGE_REG_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
